// File: rtl/episode_tracker.sv
// Winner-sequence episode tracker: captures winner IDs per theta window, scores
// them against a stored episode and flags early divergence inside a window.
module episode_tracker #(
    parameter int ID_W         = 4,
    parameter int SEQ_LEN      = 4,
    parameter int DECAY        = 2,
    parameter int REPLACE_THR  = 3,
    parameter int MISMATCH_MIN = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           theta_tick,
    input  logic                           win_valid,
    input  logic [ID_W-1:0]                win_id,
    output logic [3:0]                     ep_strength,
    output logic                           ep_valid,
    output logic                           input_mismatch,
    output logic                           ep_update,
    output logic [$clog2(SEQ_LEN+1)-1:0]   match_cnt
);

    localparam int CNT_W = $clog2(SEQ_LEN + 1);
    localparam int IDX_W = $clog2(SEQ_LEN);

    localparam logic [CNT_W-1:0] SEQ_LEN_C     = CNT_W'(SEQ_LEN);
    localparam logic [3:0]       DECAY_C       = 4'(DECAY);
    localparam logic [3:0]       REPLACE_C     = 4'(REPLACE_THR);
    localparam logic [3:0]       MISMATCH_C    = 4'(MISMATCH_MIN);
    localparam logic [3:0]       STRENGTH_MAX  = 4'd15;

    // Buffers and lengths
    logic [ID_W-1:0]  cur_reg [SEQ_LEN];
    logic [ID_W-1:0]  st_reg  [SEQ_LEN];
    logic [CNT_W-1:0] cur_len_reg, cur_len_next;
    logic [CNT_W-1:0] st_len_reg,  st_len_next;

    // Output state
    logic [3:0]       ep_strength_reg, ep_strength_next;
    logic             ep_valid_reg,    ep_valid_next;
    logic             mismatch_reg,    mismatch_next;
    logic             ep_update_reg;
    logic [CNT_W-1:0] match_cnt_reg;

    // Evaluation datapath
    logic [CNT_W-1:0] eval_len;
    logic [SEQ_LEN-1:0] match_vec;
    logic [CNT_W-1:0] match_sum;
    logic             full_match;
    logic             partial_match;
    logic [3:0]       strength_dec1;
    logic [3:0]       strength_inc;
    logic [3:0]       strength_decay;
    logic             load_episode;

    // Capture / mismatch datapath
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic [ID_W-1:0]  st_at_cur;
    logic             beyond_st;
    logic             mismatch_hit;

    assign eval_len = (cur_len_reg < st_len_reg) ? cur_len_reg : st_len_reg;

    // One comparator per buffer position, masked to the overlapping prefix.
    generate
        for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_match
            assign match_vec[gi] = (CNT_W'(gi) < eval_len) && (cur_reg[gi] == st_reg[gi]);
        end
    endgenerate

    always_comb begin
        match_sum = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            match_sum = match_sum + CNT_W'(match_vec[i]);
        end
    end

    assign full_match    = (cur_len_reg == st_len_reg) && (match_sum == cur_len_reg);
    // Doubling is done one bit wider so it cannot wrap.
    assign partial_match = {match_sum, 1'b0} >= {1'b0, st_len_reg};

    assign strength_dec1  = (ep_strength_reg == 4'd0) ? 4'd0 : ep_strength_reg - 4'd1;
    assign strength_inc   = (ep_strength_reg == STRENGTH_MAX) ? STRENGTH_MAX : ep_strength_reg + 4'd1;
    assign strength_decay = (ep_strength_reg > DECAY_C) ? ep_strength_reg - DECAY_C : 4'd0;

    always_comb begin
        ep_strength_next = ep_strength_reg;
        ep_valid_next    = ep_valid_reg;
        st_len_next      = st_len_reg;
        load_episode     = 1'b0;
        if (theta_tick) begin
            if (cur_len_reg == '0) begin
                ep_strength_next = strength_dec1;
            end else if (!ep_valid_reg) begin
                load_episode     = 1'b1;
                st_len_next      = cur_len_reg;
                ep_strength_next = 4'd1;
                ep_valid_next    = 1'b1;
            end else if (full_match) begin
                ep_strength_next = strength_inc;
            end else if (partial_match) begin
                ep_strength_next = ep_strength_reg;
            end else if (strength_decay < REPLACE_C) begin
                load_episode     = 1'b1;
                st_len_next      = cur_len_reg;
                ep_strength_next = 4'd1;
            end else begin
                ep_strength_next = strength_decay;
            end
        end
    end

    // A winner arriving with the tick opens the new window at slot 0.
    assign wr_en  = win_valid && (theta_tick || (cur_len_reg < SEQ_LEN_C));
    assign wr_idx = theta_tick ? '0 : cur_len_reg;

    always_comb begin
        cur_len_next = cur_len_reg;
        if (theta_tick) begin
            cur_len_next = win_valid ? CNT_W'(1) : '0;
        end else if (wr_en) begin
            cur_len_next = cur_len_reg + CNT_W'(1);
        end
    end

    // Guard the lookup once the window has run past the buffer depth.
    assign st_at_cur    = (cur_len_reg < SEQ_LEN_C) ? st_reg[cur_len_reg[IDX_W-1:0]] : '0;
    assign beyond_st    = cur_len_reg >= st_len_reg;
    assign mismatch_hit = win_valid && ep_valid_reg && (ep_strength_reg >= MISMATCH_C)
                          && (beyond_st || (win_id != st_at_cur));

    always_comb begin
        mismatch_next = mismatch_reg;
        if (theta_tick) begin
            mismatch_next = 1'b0;
        end else if (mismatch_hit) begin
            mismatch_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                cur_reg[i] <= '0;
                st_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                // Copy uses the closing window; the coincident write lands after.
                if (load_episode) begin
                    st_reg[i] <= cur_reg[i];
                end
                if (wr_en && (wr_idx == CNT_W'(i))) begin
                    cur_reg[i] <= win_id;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_len_reg     <= '0;
            st_len_reg      <= '0;
            ep_strength_reg <= 4'd0;
            ep_valid_reg    <= 1'b0;
            mismatch_reg    <= 1'b0;
            ep_update_reg   <= 1'b0;
            match_cnt_reg   <= '0;
        end else begin
            cur_len_reg     <= cur_len_next;
            st_len_reg      <= st_len_next;
            ep_strength_reg <= ep_strength_next;
            ep_valid_reg    <= ep_valid_next;
            mismatch_reg    <= mismatch_next;
            ep_update_reg   <= theta_tick;
            if (theta_tick) begin
                match_cnt_reg <= match_sum;
            end
        end
    end

    assign ep_strength    = ep_strength_reg;
    assign ep_valid       = ep_valid_reg;
    assign input_mismatch = mismatch_reg;
    assign ep_update      = ep_update_reg;
    assign match_cnt      = match_cnt_reg;

endmodule
